// File: rtl/gpio_ser_pkg.sv
// Shared types and elaboration helpers for the GPIO serial output driver.
// Holds the FSM state enum, counter-width functions and the default reset pattern.
package gpio_ser_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        SHIFT
    } ser_state_t;

    localparam int MAX_DATA_BITS = 64;

    function automatic int div_cnt_width(input int clk_div);
        return $clog2(clk_div + 1);
    endfunction

    function automatic int bit_cnt_width(input int data_bits);
        return $clog2(data_bits + 1);
    endfunction

    // All-ones pattern of the requested width: LEDs off on an active-low board.
    function automatic logic [MAX_DATA_BITS-1:0] ones_mask(input int bits);
        logic [MAX_DATA_BITS-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_DATA_BITS; i++) begin
            if (i < bits) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/gpio_ser_tick.sv
// CLK_DIV prescaler: tick is high on the last clk cycle of every serial phase.
// The count restarts on clear so a fresh transfer always begins on a full phase.
module gpio_ser_tick
    import gpio_ser_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int CW = div_cnt_width(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = (cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/gpio_serial_out.sv
// GPIO output register with masked bus writes and a parallel-to-serial chain driver.
// Define GPIO_SER_AUTO_EN to re-send the register automatically whenever it changes.
module gpio_serial_out
    import gpio_ser_pkg::*;
#(
    parameter int                   DATA_BITS = 16,
    parameter int                   CLK_DIV   = 2,
    parameter bit                   MSB_FIRST = 1'b1,
    parameter logic [DATA_BITS-1:0] RESET_VAL = DATA_BITS'(ones_mask(DATA_BITS))
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [DATA_BITS-1:0] wr_data,
    input  logic [DATA_BITS-1:0] wr_mask,
    input  logic                 start,
    output logic [DATA_BITS-1:0] gpio_q,
    output logic                 busy,
    output logic                 done,
    output logic                 s_clk,
    output logic                 s_dout,
    output logic                 s_clrn,
    output logic                 s_oe
);

    localparam int BW = bit_cnt_width(DATA_BITS);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    ser_state_t           state;
    logic [DATA_BITS-1:0] shreg;
    logic [DATA_BITS-1:0] shreg_shifted;
    logic [DATA_BITS-1:0] gpio_next;
    logic [BW-1:0]        bit_cnt;
    logic                 tick;
    logic                 launch;

    function automatic logic first_bit(input logic [DATA_BITS-1:0] v);
        return MSB_FIRST ? v[DATA_BITS-1] : v[0];
    endfunction

    always_comb begin
        gpio_next = wr_en ? ((gpio_q & ~wr_mask) | (wr_data & wr_mask)) : gpio_q;
    end

    always_comb begin
        shreg_shifted = MSB_FIRST ? {shreg[DATA_BITS-2:0], 1'b0}
                                  : {1'b0, shreg[DATA_BITS-1:1]};
    end

`ifdef GPIO_SER_AUTO_EN
    logic pending;
    logic changed;

    assign changed = (gpio_next != gpio_q);
    assign launch  = (state == IDLE) && (start || pending);

    // A launch ships gpio_next, so a change landing on the launch cycle is already covered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= 1'b0;
        end else if (launch) begin
            pending <= 1'b0;
        end else if (changed || start) begin
            pending <= 1'b1;
        end
    end
`else
    assign launch = (state == IDLE) && start;
`endif

    gpio_ser_tick #(
        .CLK_DIV(CLK_DIV)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clear(launch),
        .tick (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gpio_q <= RESET_VAL;
        end else begin
            gpio_q <= gpio_next;
        end
    end

    // Frame FSM: the snapshot lives in shreg, so bus writes never disturb a frame in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            s_clk   <= 1'b0;
            s_dout  <= 1'b0;
            s_clrn  <= 1'b1;
            s_oe    <= 1'b1;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (launch) begin
                        shreg   <= gpio_next;
                        bit_cnt <= '0;
                        busy    <= 1'b1;
                        s_clrn  <= 1'b0;
                        s_oe    <= 1'b0;
                        state   <= CLEAR;
                    end
                end
                CLEAR: begin
                    if (tick) begin
                        s_clrn <= 1'b1;
                        s_dout <= first_bit(shreg);
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (tick) begin
                        if (!s_clk) begin
                            s_clk <= 1'b1;
                        end else begin
                            s_clk <= 1'b0;
                            shreg <= shreg_shifted;
                            if (bit_cnt == LAST_BIT) begin
                                s_dout <= 1'b0;
                                s_oe   <= 1'b1;
                                busy   <= 1'b0;
                                done   <= 1'b1;
                                state  <= IDLE;
                            end else begin
                                s_dout  <= first_bit(shreg_shifted);
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
